// File: rtl/scale_pass_sequencer_pkg.sv
// rtl/scale_pass_sequencer_pkg.sv - shared encodings, defaults and config helpers for the scaling pass sequencer
package scale_pass_sequencer_pkg;

  typedef enum logic [1:0] {
    S_NN = 2'b00,
    S_PR = 2'b01,
    S_DC = 2'b10,
    S_BA = 2'b11
  } alg_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    FIN
  } state_e;

  // Reduction modes only support 1x and 2x (2x2 blocks keep the accumulator at PIX_W+2 bits)
  localparam int REDUCE_SHIFT_MAX = 1;
  localparam int SRC_W_DEF        = 160;
  localparam int SRC_H_DEF        = 120;
  localparam int COORD_W          = 12;

  function automatic logic is_reduce(input alg_e alg);
    return (alg == S_DC) || (alg == S_BA);
  endfunction

  function automatic logic cfg_invalid(input logic [1:0] alg, input logic [1:0] shift);
    return is_reduce(alg_e'(alg)) && (shift > 2'(REDUCE_SHIFT_MAX));
  endfunction

endpackage

// File: rtl/scale_pass_sequencer_if.sv
// rtl/scale_pass_sequencer_if.sv - source ROM read port and framebuffer write port bundle
interface scale_pass_sequencer_if #(
  parameter int PIX_W     = 8,
  parameter int RD_ADDR_W = 15,
  parameter int WR_ADDR_W = 21
);
  logic                 RD_EN;
  logic [RD_ADDR_W-1:0] RD_ADDR;
  logic [PIX_W-1:0]     RD_DATA;
  logic                 WR_VALID;
  logic                 WR_READY;
  logic [WR_ADDR_W-1:0] WR_ADDR;
  logic [PIX_W-1:0]     WR_DATA;

  modport master (
    output RD_EN, RD_ADDR,
    input  RD_DATA,
    output WR_VALID, WR_ADDR, WR_DATA,
    input  WR_READY
  );

  modport slave (
    input  RD_EN, RD_ADDR,
    output RD_DATA,
    input  WR_VALID, WR_ADDR, WR_DATA,
    output WR_READY
  );
endinterface

// File: rtl/scale_coord_gen.sv
// rtl/scale_coord_gen.sv - output raster and block sample counters, last flags, ROM and framebuffer addresses
module scale_coord_gen
  import scale_pass_sequencer_pkg::*;
#(
  parameter int SRC_W     = SRC_W_DEF,
  parameter int SRC_H     = SRC_H_DEF,
  parameter int RD_ADDR_W = 15,
  parameter int WR_ADDR_W = 21
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_reduce,
  input  logic [1:0]           i_shift,
  input  logic                 i_sample_adv,
  input  logic                 i_pix_adv,
  output logic [RD_ADDR_W-1:0] o_rd_addr,
  output logic [WR_ADDR_W-1:0] o_wr_addr,
  output logic                 o_last_pix,
  output logic                 o_last_sample
);

  localparam logic [COORD_W-1:0]   W_SRC      = COORD_W'(SRC_W);
  localparam logic [COORD_W-1:0]   H_SRC      = COORD_W'(SRC_H);
  localparam logic [COORD_W-1:0]   C_ONE      = COORD_W'(1);
  localparam logic [RD_ADDR_W-1:0] ROW_STRIDE = RD_ADDR_W'(SRC_W);

  logic [COORD_W-1:0]   r_ox;
  logic [COORD_W-1:0]   r_oy;
  logic                 r_dx;
  logic                 r_dy;
  logic [WR_ADDR_W-1:0] r_wr_addr;

  logic [COORD_W-1:0]   w_ox_max;
  logic [COORD_W-1:0]   w_oy_max;
  logic [COORD_W-1:0]   w_sx;
  logic [COORD_W-1:0]   w_sy;
  logic                 w_blk_max;

  assign w_ox_max = (i_reduce ? (W_SRC >> i_shift) : (W_SRC << i_shift)) - C_ONE;
  assign w_oy_max = (i_reduce ? (H_SRC >> i_shift) : (H_SRC << i_shift)) - C_ONE;

  // Block side is 1 or 2 samples, so one bit per block offset suffices
  assign w_blk_max = (i_shift != 2'd0);

  assign w_sx = i_reduce ? ((r_ox << i_shift) + COORD_W'(r_dx)) : (r_ox >> i_shift);
  assign w_sy = i_reduce ? ((r_oy << i_shift) + COORD_W'(r_dy)) : (r_oy >> i_shift);

  assign o_rd_addr     = RD_ADDR_W'(w_sy) * ROW_STRIDE + RD_ADDR_W'(w_sx);
  assign o_wr_addr     = r_wr_addr;
  assign o_last_pix    = (r_ox == w_ox_max) && (r_oy == w_oy_max);
  assign o_last_sample = (r_dx == w_blk_max) && (r_dy == w_blk_max);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_ox      <= '0;
      r_oy      <= '0;
      r_dx      <= 1'b0;
      r_dy      <= 1'b0;
      r_wr_addr <= '0;
    end else if (i_pix_adv) begin
      r_dx      <= 1'b0;
      r_dy      <= 1'b0;
      r_wr_addr <= r_wr_addr + WR_ADDR_W'(1);
      if (r_ox == w_ox_max) begin
        r_ox <= '0;
        r_oy <= r_oy + C_ONE;
      end else begin
        r_ox <= r_ox + C_ONE;
      end
    end else if (i_sample_adv) begin
      if (r_dx == w_blk_max) begin
        r_dx <= 1'b0;
        r_dy <= ~r_dy;
      end else begin
        r_dx <= ~r_dx;
      end
    end
  end

endmodule

// File: rtl/scale_pass_sequencer.sv
// rtl/scale_pass_sequencer.sv - scaling pass FSM, block accumulator and framebuffer handshake
// Define SCALE_STALL_CNT_EN to build the write-stall cycle counter behind STALL_CYCLES.
module scale_pass_sequencer
  import scale_pass_sequencer_pkg::*;
#(
  parameter int SRC_W     = SRC_W_DEF,
  parameter int SRC_H     = SRC_H_DEF,
  parameter int PIX_W     = 8,
  parameter int RD_ADDR_W = 15,
  parameter int WR_ADDR_W = 21
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [1:0]            ALGORITHM,
  input  logic [1:0]            SHIFT_FACTOR,
  scale_pass_sequencer_if.master bus,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  CFG_ERR,
  output logic [23:0]           STALL_CYCLES
);

  localparam int ACC_W = PIX_W + 2;

  state_e           r_state;
  state_e           w_state_nxt;
  alg_e             r_alg;
  logic [1:0]       r_shift;
  logic [ACC_W-1:0] r_acc;
  logic [PIX_W-1:0] r_wr_data;
  logic             r_cfg_err;

  logic [ACC_W-1:0] w_acc_sum;
  logic             w_start_ok;
  logic             w_start_bad;
  logic             w_is_ba;
  logic             w_sample_adv;
  logic             w_pix_adv;
  logic             w_last_pix;
  logic             w_last_sample;

  assign w_start_bad = (r_state == IDLE) && START && cfg_invalid(ALGORITHM, SHIFT_FACTOR);
  assign w_start_ok  = (r_state == IDLE) && START && !cfg_invalid(ALGORITHM, SHIFT_FACTOR);
  assign w_is_ba     = (r_alg == S_BA);
  assign w_acc_sum   = r_acc + ACC_W'(bus.RD_DATA);

  scale_coord_gen #(
    .SRC_W     (SRC_W),
    .SRC_H     (SRC_H),
    .RD_ADDR_W (RD_ADDR_W),
    .WR_ADDR_W (WR_ADDR_W)
  ) u_coord (
    .i_clk         (CLK),
    .i_rst         (RESET),
    .i_clear       (w_start_ok),
    .i_reduce      (is_reduce(r_alg)),
    .i_shift       (r_shift),
    .i_sample_adv  (w_sample_adv),
    .i_pix_adv     (w_pix_adv),
    .o_rd_addr     (bus.RD_ADDR),
    .o_wr_addr     (bus.WR_ADDR),
    .o_last_pix    (w_last_pix),
    .o_last_sample (w_last_sample)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sample_adv = 1'b0;
    w_pix_adv    = 1'b0;
    case (r_state)
      IDLE: if (w_start_ok) w_state_nxt = RD;
      RD:   w_state_nxt = CAP;
      CAP: begin
        if (w_is_ba && !w_last_sample) begin
          w_sample_adv = 1'b1;
          w_state_nxt  = RD;
        end else begin
          w_state_nxt = WR;
        end
      end
      WR: begin
        if (bus.WR_READY) begin
          if (w_last_pix) begin
            w_state_nxt = FIN;
          end else begin
            w_pix_adv   = 1'b1;
            w_state_nxt = RD;
          end
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // WR_DATA only changes in CAP, so it stays stable for the whole WR stall
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_alg     <= S_NN;
      r_shift   <= '0;
      r_acc     <= '0;
      r_wr_data <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_start_bad;
      if (w_start_ok) begin
        r_alg   <= alg_e'(ALGORITHM);
        r_shift <= SHIFT_FACTOR;
        r_acc   <= '0;
      end else if (r_state == CAP) begin
        if (!w_is_ba) begin
          r_wr_data <= bus.RD_DATA;
        end else if (!w_last_sample) begin
          r_acc <= w_acc_sum;
        end else begin
          r_wr_data <= PIX_W'(w_acc_sum >> {r_shift, 1'b0});
        end
      end else if (w_pix_adv) begin
        r_acc <= '0;
      end
    end
  end

  assign bus.RD_EN    = (r_state == RD);
  assign bus.WR_VALID = (r_state == WR);
  assign bus.WR_DATA  = r_wr_data;
  assign BUSY         = (r_state == RD) || (r_state == CAP) || (r_state == WR);
  assign DONE         = (r_state == FIN);
  assign CFG_ERR      = r_cfg_err;

`ifdef SCALE_STALL_CNT_EN
  logic [23:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (RESET || w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (bus.WR_VALID && !bus.WR_READY && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 24'd1;
    end
  end

  assign STALL_CYCLES = r_stall_cnt;
`else
  assign STALL_CYCLES = '0;
`endif

endmodule

// File: tb/tb_scale_pass_sequencer.sv
// tb/tb_scale_pass_sequencer.sv - directed table-driven bench for scale_pass_sequencer on a 16x12 source
module tb_scale_pass_sequencer;
  import scale_pass_sequencer_pkg::*;

  localparam int SRC_W = 16;
  localparam int SRC_H = 12;
  localparam int NPIX  = SRC_W * SRC_H;

  typedef struct {
    logic [1:0] alg;
    int         s;
    bit         rnd;
    int         writes;
    int         reads;
    int         probe_n;
    int         probe_addr;
    int         first;
  } pass_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [1:0]  ALGORITHM;
  logic [1:0]  SHIFT_FACTOR;
  logic        BUSY;
  logic        DONE;
  logic        CFG_ERR;
  logic [23:0] STALL_CYCLES;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [0:NPIX-1];
  pass_t      tbl [8];

  scale_pass_sequencer_if #(.PIX_W(8), .RD_ADDR_W(15), .WR_ADDR_W(21)) bus ();

  scale_pass_sequencer #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .ALGORITHM    (ALGORITHM),
    .SHIFT_FACTOR (SHIFT_FACTOR),
    .bus          (bus),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .CFG_ERR      (CFG_ERR),
    .STALL_CYCLES (STALL_CYCLES)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.RD_EN) bus.RD_DATA <= (int'(bus.RD_ADDR) < NPIX) ? rom[int'(bus.RD_ADDR)] : 8'hEE;
  end

  task automatic check(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0d expected %0d", name, row, act, exp);
    end
  endtask

  function automatic int model_pix(input logic [1:0] alg, input int s, input int n);
    int wout, ox, oy, sum;
    wout = (alg >= 2'd2) ? (SRC_W >> s) : (SRC_W << s);
    ox = n % wout;
    oy = n / wout;
    if (alg < 2'd2) return int'(rom[(oy >> s) * SRC_W + (ox >> s)]);
    if (alg == 2'd2) return int'(rom[(oy << s) * SRC_W + (ox << s)]);
    sum = 0;
    for (int dy = 0; dy < (1 << s); dy++)
      for (int dx = 0; dx < (1 << s); dx++)
        sum += int'(rom[((oy << s) + dy) * SRC_W + (ox << s) + dx]);
    return (sum >> (2 * s)) & 255;
  endfunction

  task automatic run_pass(input pass_t p, input int row);
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, stalls = 0, post = 0;
    int data_bad = 0, addr_bad = 0, hold_bad = 0, busy_bad = 0, fin_busy = 0, fin_ign_bad = 0;
    int first = -1, probe = -1;
    bit waiting = 0, done_seen = 0, fin_check = 0;
    logic [14:0] last_rd = '0;
    logic [20:0] h_addr = '0;
    logic [7:0]  h_data = '0;
    @(negedge CLK);
    START = 1'b1;
    ALGORITHM = p.alg;
    SHIFT_FACTOR = 2'(p.s);
    bus.WR_READY = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    for (int cyc = 0; cyc < 40 * p.reads + 200 && post < 4; cyc++) begin
      if (fin_check) begin
        START = 1'b0;
        if (BUSY || bus.RD_EN || CFG_ERR) fin_ign_bad++;
        fin_check = 0;
      end
      if (!done_seen) begin
        ALGORITHM = 2'($urandom);
        SHIFT_FACTOR = 2'($urandom);
      end
      bus.WR_READY = p.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.RD_EN) begin
        rd_cnt++;
        last_rd = bus.RD_ADDR;
      end
      if (waiting && (!bus.WR_VALID || bus.WR_ADDR != h_addr || bus.WR_DATA != h_data)) hold_bad++;
      waiting = 0;
      if (bus.WR_VALID) begin
        if (bus.WR_READY) begin
          if (bus.WR_ADDR != 21'(wr_cnt)) addr_bad++;
          if (int'(bus.WR_DATA) != model_pix(p.alg, p.s, wr_cnt)) data_bad++;
          if (wr_cnt == 0) first = int'(bus.WR_DATA);
          if (wr_cnt == p.probe_n) probe = int'(last_rd);
          wr_cnt++;
        end else begin
          stalls++;
          waiting = 1;
          h_addr = bus.WR_ADDR;
          h_data = bus.WR_DATA;
        end
      end
      if (DONE) begin
        done_cnt++;
        if (BUSY) fin_busy++;
        if (!done_seen) begin
          START = 1'b1;
          fin_check = 1;
        end
        done_seen = 1;
      end else if (!done_seen && !BUSY) begin
        busy_bad++;
      end
      if (done_seen) post++;
      @(negedge CLK);
    end
    START = 1'b0;
    check("pass_completed", row, int'(done_seen), 1);
    check("write_count", row, wr_cnt, p.writes);
    check("read_count", row, rd_cnt, p.reads);
    check("done_pulses", row, done_cnt, 1);
    check("wr_addr_order_errs", row, addr_bad, 0);
    check("wr_data_errs", row, data_bad, 0);
    check("stall_hold_errs", row, hold_bad, 0);
    check("busy_low_in_pass", row, busy_bad, 0);
    check("busy_high_at_done", row, fin_busy, 0);
    check("start_in_fin_taken", row, fin_ign_bad, 0);
    check("first_wr_data", row, first, p.first);
    check("probe_rd_addr", row, probe, p.probe_addr);
`ifdef SCALE_STALL_CNT_EN
    check("stall_cycles", row, int'(STALL_CYCLES), stalls);
`else
    check("stall_cycles", row, int'(STALL_CYCLES), 0);
`endif
  endtask

  task automatic check_all_zero(input string name, input int row);
    check({name, "_ctl"}, row, int'({bus.RD_EN, bus.WR_VALID, BUSY, DONE, CFG_ERR}), 0);
    check({name, "_wr_addr"}, row, int'(bus.WR_ADDR), 0);
    check({name, "_wr_data"}, row, int'(bus.WR_DATA), 0);
    check({name, "_rd_addr"}, row, int'(bus.RD_ADDR), 0);
    check({name, "_stall"}, row, int'(STALL_CYCLES), 0);
  endtask

  initial begin
    int n;
    logic [1:0] rej_alg [3];
    logic [1:0] rej_s   [3];

    for (int i = 0; i < NPIX; i++) rom[i] = 8'(i * 7 + 3);
    rom[0]         = 8'd10;
    rom[1]         = 8'd11;
    rom[SRC_W]     = 8'd20;
    rom[SRC_W + 1] = 8'd13;

    //            alg   s  rnd writes reads probe_n probe_addr first
    tbl[0] = '{S_NN, 1, 1'b0, 768, 768, 163, 33, 10};
    tbl[1] = '{S_PR, 0, 1'b0, 192, 192, 83, 83, 10};
    tbl[2] = '{S_DC, 1, 1'b0, 48, 48, 9, 34, 10};
    tbl[3] = '{S_BA, 1, 1'b0, 48, 192, 9, 51, 13};
    tbl[4] = '{S_NN, 0, 1'b1, 192, 192, 83, 83, 10};
    tbl[5] = '{S_NN, 2, 1'b0, 3072, 3072, 323, 16, 10};
    tbl[6] = '{S_BA, 0, 1'b1, 192, 192, 83, 83, 10};
    tbl[7] = '{S_DC, 0, 1'b0, 192, 192, 83, 83, 10};

    rej_alg = '{S_BA, S_DC, S_BA};
    rej_s   = '{2'd2, 2'd3, 2'd3};

    RESET = 1'b1;
    START = 1'b1;
    ALGORITHM = S_NN;
    SHIFT_FACTOR = 2'd0;
    bus.WR_READY = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset", -1);
    RESET = 1'b0;
    START = 1'b0;

    for (int i = 0; i < 8; i++) run_pass(tbl[i], i);

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      START = 1'b1;
      ALGORITHM = rej_alg[i];
      SHIFT_FACTOR = rej_s[i];
      @(negedge CLK);
      START = 1'b0;
      check("cfg_err_pulse", 100 + i, int'(CFG_ERR), 1);
      check("cfg_err_busy_rd", 100 + i, int'({BUSY, bus.RD_EN}), 0);
      @(negedge CLK);
      check("cfg_err_after", 100 + i, int'({CFG_ERR, BUSY, bus.RD_EN, DONE}), 0);
    end

    @(negedge CLK);
    START = 1'b1;
    ALGORITHM = S_NN;
    SHIFT_FACTOR = 2'd1;
    bus.WR_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 5000 && n < 500; cyc++) begin
      if (bus.WR_VALID) n++;
      @(negedge CLK);
    end
    check("midpass_writes", 200, n, 500);
    check("midpass_busy", 200, int'(BUSY), 1);
    RESET = 1'b1;
    @(negedge CLK);
    check_all_zero("midpass_reset", 200);
    RESET = 1'b0;
    run_pass(tbl[1], 201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scale_pass_sequencer.md
Name: scale_pass_sequencer

Overview:
- Sequences one full scaling pass of the coprocessor: walks every output pixel, issues source-ROM reads, optionally averages blocks, and hands each result to the framebuffer writer.
- Consumes the zoom configuration (ALGORITHM, SHIFT_FACTOR) produced by the resolution controller.
- Sits between the source image ROM (fixed 1-cycle read latency) and the framebuffer write port (valid/ready).

Parameters:
- SRC_W, 160, source image width in pixels.
- SRC_H, 120, source image height in pixels.
- PIX_W, 8, pixel width in bits.
- RD_ADDR_W, 15, source ROM address width (covers SRC_W*SRC_H = 19200).
- WR_ADDR_W, 21, framebuffer address width (covers 1280*960).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  begin a pass; sampled only in IDLE.
- ALGORITHM  in  2  00 NN, 01 PR, 10 DC, 11 BA.
- SHIFT_FACTOR  in  2  log2 of the zoom factor.
- RD_EN  out  1  ROM read strobe.
- RD_ADDR  out  RD_ADDR_W  ROM address, sy*SRC_W+sx.
- RD_DATA  in  PIX_W  ROM data, valid one cycle after RD_EN.
- WR_VALID  out  1  output pixel valid.
- WR_READY  in  1  framebuffer accepts the pixel.
- WR_ADDR  out  WR_ADDR_W  linear output address, oy*W_out+ox.
- WR_DATA  out  PIX_W  output pixel.
- BUSY  out  1  pass in progress.
- DONE  out  1  one-cycle pulse at pass end.
- CFG_ERR  out  1  one-cycle pulse when a START is rejected.
- STALL_CYCLES  out  24  stall counter (see Optional Feature).

Behaviour:
- Clock and reset: single clock CLK; RESET synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; counters, accumulator and latched configuration cleared. A RESET mid-pass aborts immediately with no further RD_EN or WR_VALID.
- Configuration: ALGORITHM and SHIFT_FACTOR are latched at the accepted START and held for the whole pass; input changes during the pass are ignored. START while BUSY is ignored.
- Rejected START: DC or BA with SHIFT_FACTOR > 1. CFG_ERR pulses 1 cycle, FSM stays IDLE, DONE is not asserted.
- Output dimensions: NN/PR give W_out = SRC_W << s, H_out = SRC_H << s. DC/BA give SRC_W >> s, SRC_H >> s. s = latched SHIFT_FACTOR.
- Source coordinates: NN/PR use sx = ox >> s, sy = oy >> s. DC/BA use block base sx = ox << s, sy = oy << s.
- Scan order: raster, ox fastest. ox wraps at W_out-1 to 0 and increments oy. WR_ADDR is kept as a running counter (+1 per accepted write, no multiplier).
- IDLE: accepted START goes to RD; BUSY=1 from the next cycle.
- RD: RD_EN=1 for 1 cycle with RD_ADDR for the current sample, then go to CAP.
- CAP: RD_DATA is captured.
  - NN/PR/DC: WR_DATA <= RD_DATA, go to WR.
  - BA: add into a PIX_W+2 bit accumulator. If samples remain in the 2^s × 2^s block (order dx fastest, then dy), go to RD. Otherwise WR_DATA <= (acc + RD_DATA) >> (2s), truncating, and go to WR.
  - BA with s=0 behaves as a 1-sample copy.
- WR: WR_VALID=1 with WR_ADDR and WR_DATA held stable until WR_READY=1. Handshake completes on the cycle where both are high; WR_VALID drops the next cycle.
  - If not the last pixel: advance ox/oy, clear the accumulator, go to RD.
  - If last pixel: go to FIN.
- FIN: DONE=1 for exactly 1 cycle, BUSY=0 in the same cycle, then IDLE. A START arriving in the FIN cycle is ignored.
- Throughput: 3 cycles per output pixel minimum (NN/PR/DC); 2·4^s+1 cycles per pixel for BA.
- Backpressure: WR_READY may be low indefinitely; no pixel is dropped or duplicated.
- Simultaneous RESET and START: RESET wins.

Optional Feature:
- Macro: SCALE_STALL_CNT_EN.
- Defined: STALL_CYCLES counts cycles with WR_VALID=1 and WR_READY=0. It clears on an accepted START, saturates at 2^24-1, and holds its value after DONE.
- Undefined: STALL_CYCLES is tied to 0 and no counter logic is built.

Decomposition:
- Shared package holds:
  - algorithm encodings S_NN/S_PR/S_DC/S_BA;
  - zoom-level constants;
  - SRC_W/SRC_H defaults;
  - the FSM state encoding IDLE/RD/CAP/WR/FIN.
- One natural sub-module, scale_coord_gen: the ox/oy/dx/dy counters, wrap detection, last-pixel flag and RD_ADDR/WR_ADDR generation. The top level keeps the FSM, accumulator and handshake.

Test Plan:
- NN, s=1, WR_READY=1: exactly 76800 writes, WR_ADDR 0..76799 in order. Output (ox=3, oy=5) reads RD_ADDR 2*160+1=321. DONE pulses once.
- DC, s=1: 80×60=4800 writes. Output (ox=1, oy=1) reads RD_ADDR 2*160+2=322.
- BA, s=1, ROM values 10, 11, 20, 13 at (0,0), (1,0), (0,1), (1,1): first write has WR_DATA=13 (54>>2); 4 RD_EN per write.
- Random WR_READY stalls on NN s=0: WR_ADDR/WR_DATA stable while stalled, 19200 unique addresses. With SCALE_STALL_CNT_EN, STALL_CYCLES equals the injected stall count.
- START with ALGORITHM=BA, s=2: CFG_ERR 1-cycle pulse, BUSY stays 0, no RD_EN.
- RESET asserted mid-pass at pixel 500: next cycle all outputs 0. A fresh START restarts at WR_ADDR 0.
